rt_port_rx: RTL and testbench

// - Router input-port receiver: decodes one serial channel (din/frame_n/valid_n) into bytes.
// - Wire format: 4 address bits LSB-first, PAD_CYCLES pad cycles, then payload bytes LSB-first.
// - frame_n rises on the last data bit.
// - Decoded bytes go into a FIFO, tagged with destination/last/error, toward the switch fabric.
// - One instance per source channel.

---
 rtl/rt_pkg.sv | 22 ++
 rtl/rt_rx_fifo.sv | 58 +++++
 rtl/rt_port_rx.sv | 205 ++++++++++++++++++++
 tb/tb_rt_port_rx.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rt_pkg.sv
// Shared types for the router input-port receiver: decoder states and the
// tagged byte entry handed to the switch fabric.
package rt_pkg;

  localparam int RT_ADDR_BITS = 4;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_ADDR,
    RX_PAD,
    RX_DATA,
    RX_DROP
  } rx_state_t;

  typedef struct packed {
    logic [RT_ADDR_BITS-1:0] dst;
    logic                    err;
    logic                    last;
    logic [7:0]              data;
  } rx_entry_t;

endpackage

// File: rtl/rt_rx_fifo.sv
// Synchronous show-ahead FIFO of receiver entries; the head is held in its own
// register so consumers see a flop output rather than a RAM read path.
module rt_rx_fifo
  import rt_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      push,
  input  rx_entry_t entry,
  output logic      full,
  input  logic      pop,
  output rx_entry_t head,
  output logic      empty
);

  localparam int PTR_W = $clog2(DEPTH);

  rx_entry_t        mem [DEPTH];
  rx_entry_t        head_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_nxt;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_nxt  = rd_ptr_q + 1'b1;
  assign head    = head_q;

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_q] <= entry;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_nxt;
      count_q <= count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
      // The incoming entry becomes head when nothing older will remain.
      if (do_push && (empty || (do_pop && count_q == (PTR_W+1)'(1))))
        head_q <= entry;
      else if (do_pop)
        head_q <= mem[rd_nxt];
    end
  end

endmodule

// File: rtl/rt_port_rx.sv
// Router input-port receiver: decodes one serial channel (address, pad, LSB-first
// payload bytes) into tagged byte entries queued toward the switch fabric.
//   state   | meaning
//   RX_IDLE | waiting for frame_n low; that cycle carries address bit 0
//   RX_ADDR | collecting the remaining address bits
//   RX_PAD  | counting pad cycles before the first data bit
//   RX_DATA | assembling payload bytes, stalling while valid_n is high
//   RX_DROP | discarding the rest of a bad frame until frame_n rises
module rt_port_rx
  import rt_pkg::*;
#(
  parameter int ADDR_BITS  = RT_ADDR_BITS,
  parameter int PAD_CYCLES = 5,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 din,
  input  logic                 frame_n,
  input  logic                 valid_n,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [7:0]           m_data,
  output logic [ADDR_BITS-1:0] m_dst,
  output logic                 m_last,
  output logic                 m_err,
  output logic                 frame_err,
  output logic                 overflow,
  output logic [15:0]          pkt_count
);

  localparam int CNT_MAX = (ADDR_BITS > PAD_CYCLES) ? ADDR_BITS : PAD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  rx_state_t            state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [7:0]           byte_q, byte_d;
  logic                 pushed_q, pushed_d;
  logic                 ferr_q, ferr_d;
  logic                 ovf_q, ovf_d;
  logic [15:0]          pkt_q, pkt_d;

  logic       push;
  logic       push_last;
  logic       push_err;
  logic [7:0] push_byte;
  logic [7:0] samp;
  rx_entry_t  push_entry;
  rx_entry_t  fifo_head;
  logic       fifo_full;
  logic       fifo_empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= RX_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      byte_q   <= '0;
      pushed_q <= 1'b0;
      ferr_q   <= 1'b0;
      ovf_q    <= 1'b0;
      pkt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      byte_q   <= byte_d;
      pushed_q <= pushed_d;
      ferr_q   <= ferr_d;
      ovf_q    <= ovf_d;
      pkt_q    <= pkt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    byte_d    = byte_q;
    pushed_d  = pushed_q;
    ferr_d    = 1'b0;
    ovf_d     = ovf_q;
    pkt_d     = pkt_q;
    push      = 1'b0;
    push_last = 1'b0;
    push_err  = 1'b0;
    push_byte = byte_q;
    samp      = byte_q;
    samp[idx_q] = din;

    unique case (state_q)
      RX_IDLE: begin
        if (!frame_n) begin
          addr_d  = ADDR_BITS'(din);
          cnt_d   = CNT_W'(1);
          state_d = RX_ADDR;
        end
      end
      RX_ADDR: begin
        if (frame_n) begin
          ferr_d  = 1'b1;
          state_d = RX_IDLE;
        end else begin
          addr_d = addr_q | (ADDR_BITS'(din) << cnt_q);
          if (cnt_q == CNT_W'(ADDR_BITS - 1)) begin
            cnt_d   = '0;
            state_d = RX_PAD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RX_PAD: begin
        if (frame_n) begin
          ferr_d  = 1'b1;
          state_d = RX_IDLE;
        end else if (valid_n) begin
          // Saturate so a longer-than-required pad is still accepted.
          if (cnt_q != CNT_W'(PAD_CYCLES)) cnt_d = cnt_q + 1'b1;
        end else if (cnt_q == CNT_W'(PAD_CYCLES)) begin
          byte_d   = {7'b0, din};
          idx_d    = 3'd1;
          pushed_d = 1'b0;
          state_d  = RX_DATA;
        end else begin
          ferr_d  = 1'b1;
          state_d = RX_DROP;
        end
      end
      RX_DATA: begin
        if (!valid_n) begin
          if (idx_q == 3'd7) begin
            push      = 1'b1;
            push_byte = samp;
            push_last = frame_n;
            idx_d     = '0;
            byte_d    = '0;
            pushed_d  = 1'b1;
            if (frame_n) begin
              state_d = RX_IDLE;
              if (!fifo_full) pkt_d = pkt_q + 16'd1;
            end else if (fifo_full) begin
              state_d = RX_DROP;
            end
          end else if (frame_n) begin
            push      = 1'b1;
            push_byte = samp;
            push_last = 1'b1;
            push_err  = 1'b1;
            ferr_d    = 1'b1;
            state_d   = RX_IDLE;
          end else begin
            byte_d = samp;
            idx_d  = idx_q + 1'b1;
          end
        end else if (frame_n) begin
          // Ending on a byte boundary leaves nothing partial to report.
          ferr_d  = 1'b1;
          state_d = RX_IDLE;
          if (!(idx_q == 3'd0 && pushed_q)) begin
            push      = 1'b1;
            push_last = 1'b1;
            push_err  = 1'b1;
          end
        end
      end
      RX_DROP: begin
        if (frame_n) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase

    if (push && fifo_full) ovf_d = 1'b1;
  end

  assign push_entry = '{dst: RT_ADDR_BITS'(addr_q), err: push_err, last: push_last, data: push_byte};

  rt_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .entry (push_entry),
    .full  (fifo_full),
    .pop   (m_ready),
    .head  (fifo_head),
    .empty (fifo_empty)
  );

  assign m_valid   = ~fifo_empty;
  assign m_data    = fifo_head.data;
  assign m_dst     = ADDR_BITS'(fifo_head.dst);
  assign m_last    = fifo_head.last;
  assign m_err     = fifo_head.err;
  assign frame_err = ferr_q;
  assign overflow  = ovf_q;
  assign pkt_count = pkt_q;

endmodule

// File: tb/tb_rt_port_rx.sv
// Directed bench for rt_port_rx: frames are described at packet level and the
// expected FIFO entries, error pulses and counters are derived from that description.
module tb_rt_port_rx;

  localparam int DEPTH = 16;

  logic        clock   = 1'b0;
  logic        reset   = 1'b1;
  logic        din     = 1'b0;
  logic        frame_n = 1'b1;
  logic        valid_n = 1'b1;
  logic        m_ready = 1'b1;
  logic        m_valid, m_last, m_err, frame_err, overflow;
  logic [7:0]  m_data;
  logic [3:0]  m_dst;
  logic [15:0] pkt_count;

  int          total = 0;
  int          bad   = 0;
  logic [13:0] exp_q[$];
  logic [7:0]  tx[$];
  int          exp_ferr = 0;
  int          obs_ferr = 0;
  int          exp_pkt  = 0;
  logic        exp_ovf  = 1'b0;
  int          pops     = 0;
  logic        ferr_prev = 1'b0;

  always #5 clock = ~clock;

  rt_port_rx #(.ADDR_BITS(4), .PAD_CYCLES(5), .FIFO_DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .din       (din),
    .frame_n   (frame_n),
    .valid_n   (valid_n),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_dst     (m_dst),
    .m_last    (m_last),
    .m_err     (m_err),
    .frame_err (frame_err),
    .overflow  (overflow),
    .pkt_count (pkt_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Compare process: every popped head against the oldest expected entry.
  always @(negedge clock) begin
    if (!reset) begin
      if (frame_err) begin
        obs_ferr++;
        check("frame_err_width", ferr_prev, 0);
      end
      ferr_prev = frame_err;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_entry: actual=%0h required=none", {m_dst, m_err, m_last, m_data});
        end else begin
          check("entry", {m_dst, m_err, m_last, m_data}, exp_q.pop_front());
          pops++;
        end
      end
    end
  end

  task automatic idle(input int n);
    {din, frame_n, valid_n} = 3'b011;
    repeat (n) begin @(posedge clock); #2; end
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    {din, frame_n, valid_n} = 3'b011;
    repeat (2) begin @(posedge clock); #2; end
    reset = 1'b0;
    exp_q.delete();
    exp_pkt = 0;
    exp_ovf = 1'b0;
  endtask

  // Build the serial cycles of one frame from tx[], update the model, then drive it.
  // trunc_bit<7 ends the last byte early; abort_at>=0 asserts reset at that cycle.
  task automatic send_frame(input logic [3:0] dst, input int pad, input int stall_at,
                            input int stall_len, input int trunc_bit, input int abort_at);
    logic [2:0] cyc[$];
    int         done_at[$];
    int         n, bitno, room;
    logic       fin, last, err;
    logic [7:0] cur, d;
    n = tx.size();
    bitno = 0;
    for (int i = 0; i < 4; i++) cyc.push_back({dst[i], 2'b01});
    for (int i = 0; i < pad; i++) cyc.push_back(3'b001);
    for (int b = 0; b < n; b++) begin
      cur = tx[b];
      for (int j = 0; j < 8; j++) begin
        fin = (b == n - 1) && (j == 7 || j == trunc_bit);
        if (bitno == stall_at) repeat (stall_len) cyc.push_back(3'b001);
        cyc.push_back({cur[j], fin, 1'b0});
        bitno++;
        if (fin) break;
      end
      done_at.push_back(cyc.size() - 1);
    end

    if (pad < 5) begin
      exp_ferr++;
    end else begin
      room = m_ready ? 1000 : DEPTH - exp_q.size();
      for (int b = 0; b < n; b++) begin
        if (abort_at >= 0 && done_at[b] >= abort_at - 1) break;
        d    = tx[b];
        last = (b == n - 1);
        err  = 1'b0;
        if (last && trunc_bit < 7) begin
          for (int k = trunc_bit + 1; k < 8; k++) d[k] = 1'b0;
          err = 1'b1;
          exp_ferr++;
        end
        if (room == 0) begin
          exp_ovf = 1'b1;
          break;
        end
        exp_q.push_back({dst, err, last, d});
        room--;
        if (last && !err) exp_pkt++;
      end
    end

    for (int i = 0; i < cyc.size(); i++) begin
      if (i == abort_at) begin
        reset = 1'b1;
        @(posedge clock); #2;
        reset = 1'b0;
        {din, frame_n, valid_n} = 3'b011;
        check("rst_m_valid", m_valid, 0);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_overflow", overflow, 0);
        exp_q.delete();
        exp_pkt = 0;
        exp_ovf = 1'b0;
        break;
      end
      {din, frame_n, valid_n} = cyc[i];
      @(posedge clock); #2;
    end
  endtask

  task automatic checkpoint(input string name);
    int budget;
    budget = 400;
    {din, frame_n, valid_n} = 3'b011;
    while ((exp_q.size() != 0 || m_valid) && budget > 0) begin
      @(posedge clock); #2;
      budget--;
    end
    repeat (2) begin @(posedge clock); #2; end
    check({name, "_m_valid"}, m_valid, 0);
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_pkt_count"}, pkt_count, exp_pkt);
    check({name, "_overflow"}, overflow, exp_ovf);
    check({name, "_frame_err"}, obs_ferr, exp_ferr);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b0;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_dst", m_dst, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_err", m_err, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overflow", overflow, 0);
    check("rst_pkt_count", pkt_count, 0);

    tx = '{8'h3C, 8'hA5};
    send_frame(4'hA, 5, -1, 0, 7, -1);
    check("nom_m_valid", m_valid, 1);
    check("nom_m_data", m_data, 8'hA5);
    check("nom_m_last", m_last, 1);
    check("nom_m_dst", m_dst, 4'hA);
    check("nom_pkt_count", pkt_count, 1);
    checkpoint("nominal");

    tx = '{8'h3C, 8'hA5};
    send_frame(4'hA, 5, 11, 3, 7, -1);
    checkpoint("stall");

    tx = '{8'h55};
    send_frame(4'h7, 3, -1, 0, 7, -1);
    idle(2);
    tx = '{8'h81, 8'h7E};
    send_frame(4'h5, 5, -1, 0, 7, -1);
    checkpoint("short_pad");

    m_ready = 1'b0;
    tx = '{8'hFF};
    send_frame(4'h3, 5, -1, 0, 4, -1);
    check("sf_m_valid", m_valid, 1);
    check("sf_m_data", m_data, 8'h1F);
    check("sf_m_last", m_last, 1);
    check("sf_m_err", m_err, 1);
    check("sf_pkt_count", pkt_count, 3);
    m_ready = 1'b1;
    checkpoint("short_frame");

    tx = '{8'h12};
    send_frame(4'h1, 5, -1, 0, 7, -1);
    tx = '{8'h34, 8'h56};
    send_frame(4'h2, 5, -1, 0, 7, -1);
    checkpoint("back2back");

    reset_dut();
    m_ready = 1'b0;
    tx.delete();
    for (int i = 0; i < 20; i++) tx.push_back(8'(i * 37 + 11));
    send_frame(4'h9, 5, -1, 0, 7, -1);
    check("ovf_overflow", overflow, 1);
    check("ovf_pkt_count", pkt_count, 0);
    check("ovf_m_valid", m_valid, 1);
    pops = 0;
    m_ready = 1'b1;
    checkpoint("overflow");
    check("ovf_entries", pops, 16);

    tx = '{8'hC3, 8'h5A, 8'h99};
    send_frame(4'h6, 5, -1, 0, 7, 20);
    idle(1);
    tx = '{8'hDE, 8'hAD};
    send_frame(4'hF, 5, -1, 0, 7, -1);
    check("post_rst_pkt_count", pkt_count, 1);
    checkpoint("reset_mid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
